// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard front-end.
package kbd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } frame_state_e;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Letter keys are the only ones whose case follows Caps Lock.
    function automatic logic is_letter(input logic [7:0] sc);
        case (sc)
            8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/kbd_scan2ascii.sv
// Combinational set-2 scan code to ASCII lookup; unmapped codes give 0.
module kbd_scan2ascii (
    input  logic [7:0] scan,
    input  logic       shift,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (scan)
            8'h1C: ascii = shift ? "A" : "a";
            8'h32: ascii = shift ? "B" : "b";
            8'h21: ascii = shift ? "C" : "c";
            8'h23: ascii = shift ? "D" : "d";
            8'h24: ascii = shift ? "E" : "e";
            8'h2B: ascii = shift ? "F" : "f";
            8'h34: ascii = shift ? "G" : "g";
            8'h33: ascii = shift ? "H" : "h";
            8'h43: ascii = shift ? "I" : "i";
            8'h3B: ascii = shift ? "J" : "j";
            8'h42: ascii = shift ? "K" : "k";
            8'h4B: ascii = shift ? "L" : "l";
            8'h3A: ascii = shift ? "M" : "m";
            8'h31: ascii = shift ? "N" : "n";
            8'h44: ascii = shift ? "O" : "o";
            8'h4D: ascii = shift ? "P" : "p";
            8'h15: ascii = shift ? "Q" : "q";
            8'h2D: ascii = shift ? "R" : "r";
            8'h1B: ascii = shift ? "S" : "s";
            8'h2C: ascii = shift ? "T" : "t";
            8'h3C: ascii = shift ? "U" : "u";
            8'h2A: ascii = shift ? "V" : "v";
            8'h1D: ascii = shift ? "W" : "w";
            8'h22: ascii = shift ? "X" : "x";
            8'h35: ascii = shift ? "Y" : "y";
            8'h1A: ascii = shift ? "Z" : "z";
            8'h16: ascii = shift ? "!" : "1";
            8'h1E: ascii = shift ? "@" : "2";
            8'h26: ascii = shift ? "#" : "3";
            8'h25: ascii = shift ? "$" : "4";
            8'h2E: ascii = shift ? "%" : "5";
            8'h36: ascii = shift ? "^" : "6";
            8'h3D: ascii = shift ? "&" : "7";
            8'h3E: ascii = shift ? "*" : "8";
            8'h46: ascii = shift ? "(" : "9";
            8'h45: ascii = shift ? ")" : "0";
            8'h0E: ascii = shift ? "~" : 8'h60;
            8'h4E: ascii = shift ? "_" : "-";
            8'h55: ascii = shift ? "+" : "=";
            8'h54: ascii = shift ? "{" : "[";
            8'h5B: ascii = shift ? "}" : "]";
            8'h5D: ascii = shift ? "|" : 8'h5C;
            8'h4C: ascii = shift ? ":" : ";";
            8'h52: ascii = shift ? 8'h22 : "'";
            8'h41: ascii = shift ? "<" : ",";
            8'h49: ascii = shift ? ">" : ".";
            8'h4A: ascii = shift ? "?" : "/";
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            8'h66: ascii = 8'h08;
            8'h0D: ascii = 8'h09;
            8'h76: ascii = 8'h1B;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: conditioning, framing, make/break decode and an
// ASCII first-word-fall-through FIFO for the MCU.
module ps2_kbd_fifo
    import kbd_pkg::*;
#(
    parameter int unsigned CLK_MHZ    = 50,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2k_clk,
    input  logic       ps2k_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       overflow,
    output logic       frame_err,
    input  logic       err_clr
);

    localparam int unsigned TO_CYC = CLK_MHZ * TIMEOUT_US;
    localparam int unsigned TW     = $clog2(TO_CYC + 1);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);

    logic [1:0] kclk_sync_q, kdat_sync_q;
    logic [2:0] kclk_hist_q, kdat_hist_q;
    logic       kclk_filt_q, kdat_filt_q;
    logic       sample_evt;

    // Synchronizers idle high like the bus; filter flips after 3 equal samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kclk_sync_q <= 2'b11;
            kdat_sync_q <= 2'b11;
            kclk_hist_q <= 3'b111;
            kdat_hist_q <= 3'b111;
            kclk_filt_q <= 1'b1;
            kdat_filt_q <= 1'b1;
        end else begin
            kclk_sync_q <= {kclk_sync_q[0], ps2k_clk};
            kdat_sync_q <= {kdat_sync_q[0], ps2k_data};
            kclk_hist_q <= {kclk_hist_q[1:0], kclk_sync_q[1]};
            kdat_hist_q <= {kdat_hist_q[1:0], kdat_sync_q[1]};
            if (&kclk_hist_q)       kclk_filt_q <= 1'b1;
            else if (~|kclk_hist_q) kclk_filt_q <= 1'b0;
            if (&kdat_hist_q)       kdat_filt_q <= 1'b1;
            else if (~|kdat_hist_q) kdat_filt_q <= 1'b0;
        end
    end

    assign sample_evt = kclk_filt_q & ~|kclk_hist_q;

    frame_state_e  state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q, byte_q;
    logic          par_ok_q, byte_vld_q, frame_bad_q;
    logic [TW-1:0] to_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            byte_q      <= '0;
            par_ok_q    <= 1'b0;
            byte_vld_q  <= 1'b0;
            frame_bad_q <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            byte_vld_q  <= 1'b0;
            frame_bad_q <= 1'b0;
            if (state_q == StIdle) begin
                if (sample_evt && !kdat_filt_q) begin
                    state_q   <= StData;
                    bit_cnt_q <= '0;
                    to_cnt_q  <= TW'(TO_CYC);
                end
            end else if (sample_evt) begin
                to_cnt_q <= TW'(TO_CYC);
                if (state_q == StData) begin
                    shreg_q   <= {kdat_filt_q, shreg_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_q <= StParity;
                end else if (state_q == StParity) begin
                    par_ok_q <= ^{shreg_q, kdat_filt_q};
                    state_q  <= StStop;
                end else begin
                    state_q <= StIdle;
                    if (par_ok_q && kdat_filt_q) begin
                        byte_q     <= shreg_q;
                        byte_vld_q <= 1'b1;
                    end else begin
                        frame_bad_q <= 1'b1;
                    end
                end
            end else if (to_cnt_q == '0) begin
                state_q     <= StIdle;
                frame_bad_q <= 1'b1;
            end else begin
                to_cnt_q <= to_cnt_q - TW'(1);
            end
        end
    end

    logic       brk_q, ext_q, shift_q, caps_q, char_vld_q;
    logic [7:0] char_q, ascii;

    kbd_scan2ascii u_scan2ascii (
        .scan  (byte_q),
        .shift (shift_q ^ (caps_q & is_letter(byte_q))),
        .ascii (ascii)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            shift_q    <= 1'b0;
            caps_q     <= 1'b0;
            char_q     <= '0;
            char_vld_q <= 1'b0;
        end else begin
            char_vld_q <= 1'b0;
            if (byte_vld_q) begin
                if (byte_q == SC_BREAK) begin
                    brk_q <= 1'b1;
                end else if (byte_q == SC_EXT) begin
                    ext_q <= 1'b1;
                end else begin
                    brk_q <= 1'b0;
                    ext_q <= 1'b0;
                    if (byte_q == SC_LSHIFT || byte_q == SC_RSHIFT) begin
                        shift_q <= ~brk_q;
                    end else if (byte_q == SC_CAPS) begin
                        if (!brk_q) caps_q <= ~caps_q;
                    end else if (!brk_q && !ext_q && ascii != 8'h00) begin
                        char_q     <= ascii;
                        char_vld_q <= 1'b1;
                    end
                end
            end
        end
    end

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, pop, push;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign pop   = rd_en & ~empty;
    // A pop frees the head slot in the same edge, so a full FIFO still accepts.
    assign push  = char_vld_q & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= char_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (err_clr)                       overflow <= 1'b0;
            else if (char_vld_q && full && !pop) overflow <= 1'b1;
            if (err_clr)          frame_err <= 1'b0;
            else if (frame_bad_q) frame_err <= 1'b1;
        end
    end

    assign rd_valid = ~empty;
    assign rd_data  = empty ? 8'h00 : mem[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Directed plus randomized PS/2 frames against a keystroke-level reference model.
module tb_ps2_kbd_fifo;

    localparam int unsigned CLK_MHZ    = 2;
    localparam int unsigned TIMEOUT_US = 100;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned HALF       = 10;
    localparam int unsigned TO_CYC     = CLK_MHZ * TIMEOUT_US;

    logic       clk = 1'b0;
    logic       reset, ps2k_clk, ps2k_data, rd_en, err_clr;
    logic [7:0] rd_data;
    logic       rd_valid, overflow, frame_err;

    always #5 clk = ~clk;

    ps2_kbd_fifo #(
        .CLK_MHZ    (CLK_MHZ),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_US (TIMEOUT_US)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2k_clk  (ps2k_clk),
        .ps2k_data (ps2k_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .overflow  (overflow),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    int vectors = 0;
    int miscompares = 0;

    byte unsigned exp_q[$];
    bit m_brk, m_ext, m_shift, m_caps, m_ovf, m_ferr;

    byte unsigned let_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned oth_sc[26] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                 8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
                                 8'h41, 8'h49, 8'h4A, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    byte unsigned oth_lo[26] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                 8'h30, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
                                 8'h2C, 8'h2E, 8'h2F, 8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};
    byte unsigned oth_hi[26] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28,
                                 8'h29, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
                                 8'h3C, 8'h3E, 8'h3F, 8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};
    byte unsigned pool[18] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h1E, 8'h45, 8'h4E, 8'h29, 8'h5A,
                               8'h12, 8'h59, 8'h58, 8'hF0, 8'hF0, 8'hE0, 8'h05, 8'h76, 8'h52};

    function automatic byte unsigned model_ascii(input byte unsigned sc);
        for (int i = 0; i < 26; i++)
            if (let_sc[i] == sc) return 8'((m_shift ^ m_caps) ? 8'h41 + i : 8'h61 + i);
        for (int i = 0; i < 26; i++)
            if (oth_sc[i] == sc) return m_shift ? oth_hi[i] : oth_lo[i];
        return 8'h00;
    endfunction

    task automatic model_byte(input byte unsigned b);
        byte unsigned a;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
            else if (b == 8'h58) begin
                if (!m_brk) m_caps = !m_caps;
            end else if (!m_brk && !m_ext) begin
                a = model_ascii(b);
                if (a != 8'h00) begin
                    if (exp_q.size() == DEPTH) m_ovf = 1'b1;
                    else exp_q.push_back(a);
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        check({tag, ".rd_valid"}, {7'b0, rd_valid}, {7'b0, exp_q.size() != 0});
        check({tag, ".rd_data"}, rd_data, head);
        check({tag, ".overflow"}, {7'b0, overflow}, {7'b0, m_ovf});
        check({tag, ".frame_err"}, {7'b0, frame_err}, {7'b0, m_ferr});
    endtask

    // Bit-level PS/2 device; nbits < 11 sends a truncated frame.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_at_push,
                              input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < nbits; i++) begin
            ps2k_data = bits[i];
            repeat (HALF) @(posedge clk);
            #1 ps2k_clk = 1'b0;
            if (i == 10 && pop_at_push) begin
                // Push lands on the 8th edge after the stop-bit falling edge.
                repeat (7) @(posedge clk);
                #1 rd_en = 1'b1;
                @(posedge clk);
                #1 rd_en = 1'b0;
                repeat (HALF - 8) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            #1 ps2k_clk = 1'b1;
        end
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
        model_byte(b);
    endtask

    task automatic pop(input string tag);
        check_all(tag);
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    initial begin
        int r;
        reset = 1'b1; ps2k_clk = 1'b1; ps2k_data = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_all("reset");
        reset = 1'b0;
        repeat (4) @(posedge clk);

        key(8'h1C);
        check_all("plain_a");
        pop("pop_a");
        check_all("after_pop");

        key(8'h12); key(8'h1C); key(8'hF0); key(8'h1C); key(8'hF0); key(8'h12); key(8'h1C);
        pop("shift_A");
        pop("unshift_a");
        check_all("shift_empty");

        key(8'h58); key(8'hF0); key(8'h58); key(8'h16);
        pop("caps_digit");
        key(8'h1C);
        pop("caps_letter");
        key(8'h58);

        send_frame(8'h1C, 1'b1, 1'b0, 11);
        m_ferr = 1'b1;
        check_all("bad_parity");
        clear_errs();
        check_all("err_clr");

        for (int i = 0; i < 9; i++) key(8'h1C);
        check_all("overflow");
        clear_errs();
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        void'(exp_q.pop_front());
        model_byte(8'h1C);
        check_all("full_push_pop");
        for (int i = 0; i < 8; i++) pop("drain");
        check_all("drained");
        pop("pop_empty");
        check_all("pop_empty_after");

        send_frame(8'h32, 1'b0, 1'b0, 5);
        repeat (TO_CYC + 50) @(posedge clk);
        #1 m_ferr = 1'b1;
        check_all("timeout");
        clear_errs();
        key(8'h32);
        pop("after_timeout_b");

        key(8'h21); key(8'h12);
        send_frame(8'h1C, 1'b0, 1'b0, 4);
        reset = 1'b1;
        #1;
        exp_q.delete();
        m_brk = 0; m_ext = 0; m_shift = 0; m_caps = 0; m_ovf = 0; m_ferr = 0;
        check_all("reset_midframe");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        key(8'h1C);
        pop("post_reset_a");

        for (int n = 0; n < 70; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) pop("rnd_pop");
            else if (r == 2) begin
                send_frame(pool[$urandom_range(0, 17)], 1'b1, 1'b0, 11);
                m_ferr = 1'b1;
            end else if (r == 3) clear_errs();
            else key(pool[$urandom_range(0, 17)]);
            check_all("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_fifo.md
# ps2_kbd_fifo

PS/2 keyboard front-end that replaces the bare scan-to-byte path feeding MCU input port 4. It receives raw PS/2 frames, checks framing and parity, and tracks make/break, extended, Shift and Caps Lock state. It converts make codes to ASCII and buffers the characters in a small first-word-fall-through FIFO. The MCU pops characters one at a time, so no keystroke is lost between polls.

## Interface
Parameters:
- `CLK_MHZ`, default 50: system clock frequency in MHz; used to size the timeout.
- `FIFO_DEPTH`, default 8: number of buffered characters; must be a power of two, at least 2.
- `TIMEOUT_US`, default 200: maximum gap between PS/2 clock falling edges inside a frame, in microseconds.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2k_clk`  in  1  raw PS/2 clock from the pin; asynchronous.
- `ps2k_data`  in  1  raw PS/2 data from the pin; asynchronous.
- `rd_en`  in  1  pop request; one pop per cycle.
- `rd_data`  out  8  ASCII code at the FIFO head; reads 0 when the FIFO is empty.
- `rd_valid`  out  1  FIFO not empty.
- `overflow`  out  1  sticky: a character was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a parity error, bad start/stop bit, or timeout occurred.
- `err_clr`  in  1  clears `overflow` and `frame_err`.

## Operation
- **Input conditioning:** `ps2k_clk` and `ps2k_data` each pass through a 2-flop synchronizer. A 3-sample glitch filter follows; the filtered level changes only after 3 consecutive equal samples. A falling edge of the filtered clock is one "sample event".
- **Frame FSM:** states `IDLE → DATA → PARITY → STOP → IDLE`.
  - `IDLE`: a sample event with data 0 enters `DATA`. A sample event with data 1 is ignored.
  - `DATA`: 8 sample events, shifted in LSB-first.
  - `PARITY`: checks for odd parity over the 8 data bits plus the parity bit.
  - `STOP`: data must be 1. On success the byte goes to the decoder. On any failure the byte is discarded, `frame_err` is set, and the FSM returns to `IDLE`.
- **Timeout:** outside `IDLE`, a counter of `CLK_MHZ*TIMEOUT_US` cycles restarts on every sample event. When it expires, the FSM goes to `IDLE`, sets `frame_err`, and discards the partial byte.
- **Decoder:**
  - `F0` sets `brk`. `E0` sets `ext`. Any other byte consumes and clears both flags.
  - Scan codes `12`/`59` set the shift state on a make and clear it on a break.
  - Scan code `58` make toggles `caps`; its break is ignored.
  - Other codes push a character only when the code is a make, `ext` is clear, and the ASCII result is nonzero.
  - Letters are uppercase when shift XOR caps. Non-letter keys use the shifted table when shift is held.
- **FIFO:**
  - A push when full drops the character and sets `overflow`.
  - A pop when empty is ignored.
  - A simultaneous push and pop is accepted even when full; occupancy is unchanged.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Error flags:** `err_clr` has priority over a same-cycle set.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `overflow`=0, `frame_err`=0, FSM=`IDLE`, `brk`/`ext`/shift/`caps`=0, FIFO empty.
- Input latency: 2 sync cycles plus 3 filter cycles from a pin edge to the sample event.
- The stop-bit sample event is cycle N. The decoded character is registered at N+1 and written to the FIFO at N+2. `rd_valid`=1 and `rd_data` are valid at N+2.
- When `rd_en`=1 with `rd_valid`=1 at edge k, the next entry, or empty, is visible after edge k.
- Reset asserted mid-frame aborts the frame immediately and empties the FIFO.

## Structure
- Shared package `kbd_pkg` holds:
  - the frame-state enum;
  - scan-code constants `SC_BREAK`=`F0`, `SC_EXT`=`E0`, `SC_LSHIFT`=`12`, `SC_RSHIFT`=`59`, `SC_CAPS`=`58`.
- One sub-module, `kbd_scan2ascii`: purely combinational (scan code, shift) → ASCII lookup. It returns 0 for unmapped codes.
- The FIFO is inline: a register array plus pointers with an extra wrap bit.

## Test plan
- Frame `1C` (start 0, parity 0, stop 1) → `rd_valid`=1, `rd_data`=`0x61`; pop → `rd_valid`=0.
- Sequence `12`, `1C`, `F0 1C`, `F0 12`, `1C` → FIFO holds `0x41` then `0x61`.
- `58`, `F0 58`, `16` → `0x21`? No: `16` with caps only → `0x31` (`1`, not a letter); then `1C` → `0x41`.
- `1C` with the parity bit flipped → no push, `frame_err`=1; after `err_clr`, `frame_err`=0.
- Nine `1C` makes with no pops → 8 entries, `overflow`=1. Pop and push in the same cycle while full → count stays 8.
- Start bit plus 4 data bits, then idle beyond `TIMEOUT_US` → `frame_err`=1. A following valid `32` frame → `0x62` pushed.
